fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the Stage1 fetch path. Owns the PC and issues word fetches to instruction memory over a req/ack handshake that may take several cycles. Buffers up to two fetched instructions for decode under backpressure, and applies JAL/JALR/taken-branch redirects, including discarding a response already in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
// No ports: imported by fetch_buffer and fetch_sequencer.
package fetch_pkg;
   localparam int          DEF_XLEN     = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          INSTR_BYTES  = 4;
   localparam int          FBUF_DEPTH   = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      REQ   = ST_REQ,
      DRAIN = ST_DRAIN
   } fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of {pc, instr} fetched words waiting for decode.
// Ports:
//   clk_sys, rst_b       clock, synchronous active-low reset
//   push, push_pc/instr  write one entry (never issued when full)
//   pop                  drop the head entry (ignored when empty)
//   flush                empty the buffer; outranks push/pop
//   count                number of valid entries (0..2)
//   head_pc, head_instr  contents of the oldest entry
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk_sys,
   input  logic            rst_b,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [31:0]     push_instr,
   input  logic            pop,
   input  logic            flush,
   output logic [1:0]      count,
   output logic [XLEN-1:0] head_pc,
   output logic [31:0]     head_instr
);

   logic [XLEN-1:0] pc_1;
   logic [31:0]     instr_1;
   logic            pop_ok;

   assign pop_ok = pop & (count != 2'd0);

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         count      <= 2'd0;
         head_pc    <= '0;
         head_instr <= '0;
         pc_1       <= '0;
         instr_1    <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count == 2'd0) begin
                  head_pc    <= push_pc;
                  head_instr <= push_instr;
               end else begin
                  pc_1    <= push_pc;
                  instr_1 <= push_instr;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_pc    <= pc_1;
               head_instr <= instr_1;
               count      <= count - 2'd1;
            end
            2'b11: begin
               // count stays; the new word lands wherever the old head leaves room
               if (count == 2'd1) begin
                  head_pc    <= push_pc;
                  head_instr <= push_instr;
               end else begin
                  head_pc    <= pc_1;
                  head_instr <= instr_1;
                  pc_1       <= push_pc;
                  instr_1    <= push_instr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches over a
// req/ack handshake, buffers up to two words for decode and applies
// JAL/JALR/taken-branch redirects (discarding a response still in flight).
// Ports:
//   Clk, Reset                       clock, synchronous active-low reset
//   Is_JAL, Is_JAL_R, Is_Branch_Taken, Branch_Address   redirect from execute
//   Imem_Req, Imem_Addr, Imem_Ack, Imem_Rdata           instruction memory
//   Fetch_Valid, Fetch_Pc, Fetch_Instr, Decode_Ready    decode interface
//   Pc_Out                           address of the next fetch to issue
//
// state | meaning
// IDLE  | no request; buffer full (or just out of reset)
// REQ   | request at PC outstanding; its data will be kept
// DRAIN | request outstanding at a stale address; its data will be dropped
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Is_JAL,
   input  logic            Is_JAL_R,
   input  logic            Is_Branch_Taken,
   input  logic [XLEN-1:0] Branch_Address,
   output logic            Imem_Req,
   output logic [XLEN-1:0] Imem_Addr,
   input  logic            Imem_Ack,
   input  logic [31:0]     Imem_Rdata,
   output logic            Fetch_Valid,
   output logic [XLEN-1:0] Fetch_Pc,
   output logic [31:0]     Fetch_Instr,
   input  logic            Decode_Ready,
   output logic [XLEN-1:0] Pc_Out
);

   fetch_state_e    state, next_state;
   logic [XLEN-1:0] pc, drain_addr, target;
   logic            redirect, ack_acc, pop;
   logic [1:0]      count, cnt_next;

   assign redirect = Is_JAL | Is_JAL_R | Is_Branch_Taken;
   assign target   = Branch_Address & ~XLEN'(INSTR_BYTES - 1);
   assign ack_acc  = (state == REQ) & Imem_Ack & ~redirect;
   assign pop      = Fetch_Valid & Decode_Ready & ~redirect;
   assign cnt_next = redirect ? 2'd0 : count + {1'b0, ack_acc} - {1'b0, pop};

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cnt_next < 2'(FBUF_DEPTH)) next_state = REQ;
         end
         REQ: begin
            if (Imem_Ack) begin
               next_state = (cnt_next < 2'(FBUF_DEPTH)) ? REQ : IDLE;
            end else if (redirect) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (Imem_Ack) next_state = REQ;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         drain_addr <= '0;
      end else begin
         state <= next_state;
         if (redirect) begin
            pc <= target;
         end else if (ack_acc) begin
            pc <= pc + XLEN'(INSTR_BYTES);
         end
         // Memory still owes us the old address; keep presenting it.
         if ((state == REQ) && !Imem_Ack && redirect) begin
            drain_addr <= pc;
         end
      end
   end

   assign Imem_Req    = (state != IDLE);
   assign Imem_Addr   = (state == DRAIN) ? drain_addr : pc;
   assign Pc_Out      = pc;
   assign Fetch_Valid = (count != 2'd0);

   fetch_buffer #(
      .XLEN (XLEN)
   ) u_fetch_buffer (
      .clk_sys    (Clk),
      .rst_b      (Reset),
      .push       (ack_acc),
      .push_pc    (pc),
      .push_instr (Imem_Rdata),
      .pop        (pop),
      .flush      (redirect),
      .count      (count),
      .head_pc    (Fetch_Pc),
      .head_instr (Fetch_Instr)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Is_JAL, Is_JAL_R, Is_Branch_Taken;
   logic [31:0] Branch_Address;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ack;
   logic [31:0] Imem_Rdata;
   logic        Fetch_Valid;
   logic [31:0] Fetch_Pc;
   logic [31:0] Fetch_Instr;
   logic        Decode_Ready;
   logic [31:0] Pc_Out;

   fetch_sequencer #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Is_JAL          (Is_JAL),
      .Is_JAL_R        (Is_JAL_R),
      .Is_Branch_Taken (Is_Branch_Taken),
      .Branch_Address  (Branch_Address),
      .Imem_Req        (Imem_Req),
      .Imem_Addr       (Imem_Addr),
      .Imem_Ack        (Imem_Ack),
      .Imem_Rdata      (Imem_Rdata),
      .Fetch_Valid     (Fetch_Valid),
      .Fetch_Pc        (Fetch_Pc),
      .Fetch_Instr     (Fetch_Instr),
      .Decode_Ready    (Decode_Ready),
      .Pc_Out          (Pc_Out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: one outstanding request (with a "discard" mark),
   // a queue of fetched words, and the next-fetch PC.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fent_t;

   fent_t       m_q[$];
   logic [31:0] m_pc   = 32'h0;
   logic [31:0] m_addr = 32'h0;
   bit          m_out  = 1'b0;
   bit          m_disc = 1'b0;
   bit          m_rst  = 1'b0;

   task automatic model_step();
      bit    redir, done;
      fent_t e;
      if (!Reset) begin
         m_pc   = 32'h0;
         m_out  = 1'b0;
         m_disc = 1'b0;
         m_rst  = 1'b1;
         m_q.delete();
         return;
      end
      m_rst = 1'b0;
      redir = Is_JAL | Is_JAL_R | Is_Branch_Taken;
      done  = m_out && Imem_Ack;
      if (redir) begin
         m_q.delete();
         m_pc = Branch_Address & 32'hFFFF_FFFC;
         if (m_out && !Imem_Ack) m_disc = 1'b1;
      end else begin
         if (m_q.size() > 0 && Decode_Ready) void'(m_q.pop_front());
         if (done && !m_disc) begin
            e.pc    = m_addr;
            e.instr = Imem_Rdata;
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
      if (done) begin
         m_out  = 1'b0;
         m_disc = 1'b0;
      end
      if (!m_out && m_q.size() < 2) begin
         m_out  = 1'b1;
         m_addr = m_pc;
      end
   endtask

   task automatic compare_all();
      check_val("req", 32'(Imem_Req), 32'(m_out));
      if (m_out) check_val("addr", Imem_Addr, m_addr);
      check_val("valid", 32'(Fetch_Valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check_val("fetch_pc", Fetch_Pc, m_q[0].pc);
         check_val("fetch_instr", Fetch_Instr, m_q[0].instr);
      end else if (m_rst) begin
         check_val("rst_fetch_pc", Fetch_Pc, 32'h0);
         check_val("rst_fetch_instr", Fetch_Instr, 32'h0);
      end
      check_val("pc_out", Pc_Out, m_pc);
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_in();
      Is_JAL          = 1'b0;
      Is_JAL_R        = 1'b0;
      Is_Branch_Taken = 1'b0;
      Branch_Address  = 32'h0;
      Imem_Ack        = 1'b0;
      Imem_Rdata      = 32'h0;
      Decode_Ready    = 1'b0;
   endtask

   task automatic apply_reset();
      clear_in();
      Reset = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
   endtask

   initial begin
      clear_in();
      Reset = 1'b0;

      // reset held 3 cycles with acks pulsing
      Imem_Ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rst_req", 32'(Imem_Req), 32'h0);
         check_val("rst_valid", 32'(Fetch_Valid), 32'h0);
         check_val("rst_pc_out", Pc_Out, 32'h0);
      end
      Reset    = 1'b1;
      Imem_Ack = 1'b0;
      tick();
      check_val("first_req", 32'(Imem_Req), 32'h1);
      check_val("first_addr", Imem_Addr, 32'h0);

      // streaming at one instruction per cycle
      Imem_Ack     = 1'b1;
      Decode_Ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         Imem_Rdata = $urandom;
         tick();
         check_val("stream_addr", Imem_Addr, 32'((i + 1) * 4));
         check_val("stream_fpc", Fetch_Pc, 32'(i * 4));
         check_val("stream_valid", 32'(Fetch_Valid), 32'h1);
      end

      // backpressure fills the buffer, one pop restarts fetching
      apply_reset();
      tick();
      Imem_Ack = 1'b1;
      Imem_Rdata = 32'h1111_0000;
      tick();
      Imem_Rdata = 32'h1111_0004;
      tick();
      Imem_Ack = 1'b0;
      check_val("bp_req", 32'(Imem_Req), 32'h0);
      check_val("bp_head", Fetch_Pc, 32'h0);
      tick();
      check_val("bp_req_hold", 32'(Imem_Req), 32'h0);
      Decode_Ready = 1'b1;
      tick();
      Decode_Ready = 1'b0;
      check_val("bp_req_again", 32'(Imem_Req), 32'h1);
      check_val("bp_addr", Imem_Addr, 32'h8);
      check_val("bp_head2", Fetch_Pc, 32'h4);

      // redirect while a request is in flight
      apply_reset();
      Is_Branch_Taken = 1'b1;
      Branch_Address  = 32'h10;
      tick();
      check_val("dr_addr0", Imem_Addr, 32'h10);
      Branch_Address = 32'h200;
      tick();
      Is_Branch_Taken = 1'b0;
      check_val("dr_addr1", Imem_Addr, 32'h10);
      tick();
      tick();
      check_val("dr_addr3", Imem_Addr, 32'h10);
      Imem_Ack   = 1'b1;
      Imem_Rdata = 32'hDEAD_BEEF;
      tick();
      check_val("dr_valid", 32'(Fetch_Valid), 32'h0);
      check_val("dr_new_addr", Imem_Addr, 32'h200);
      Imem_Rdata = 32'h0000_0200;
      tick();
      Imem_Ack = 1'b0;
      check_val("dr_head", Fetch_Pc, 32'h200);

      // redirect colliding with ack and pop
      apply_reset();
      tick();
      Imem_Ack = 1'b1;
      Imem_Rdata = 32'hAAAA_0000;
      tick();
      Decode_Ready   = 1'b1;
      Is_JAL_R       = 1'b1;
      Branch_Address = 32'h203;
      tick();
      clear_in();
      check_val("col_valid", 32'(Fetch_Valid), 32'h0);
      check_val("col_addr", Imem_Addr, 32'h200);
      check_val("col_pc_out", Pc_Out, 32'h200);

      // PC wraps past the top of the address space
      apply_reset();
      Is_JAL         = 1'b1;
      Branch_Address = 32'hFFFF_FFFC;
      tick();
      Is_JAL = 1'b0;
      check_val("wrap_addr0", Imem_Addr, 32'hFFFF_FFFC);
      Imem_Ack     = 1'b1;
      Decode_Ready = 1'b1;
      Imem_Rdata   = 32'h5555_AAAA;
      tick();
      clear_in();
      check_val("wrap_addr1", Imem_Addr, 32'h0);
      check_val("wrap_head", Fetch_Pc, 32'hFFFF_FFFC);

      // reset while draining, then a stray ack
      apply_reset();
      Is_JAL         = 1'b1;
      Branch_Address = 32'h40;
      tick();
      Branch_Address = 32'h80;
      tick();
      Is_JAL = 1'b0;
      check_val("rd_drain_addr", Imem_Addr, 32'h40);
      Reset = 1'b0;
      tick();
      check_val("rd_req_off", 32'(Imem_Req), 32'h0);
      Reset      = 1'b1;
      Imem_Ack   = 1'b1;
      Imem_Rdata = 32'hBAD0_BAD0;
      tick();
      Imem_Ack = 1'b0;
      check_val("rd_valid", 32'(Fetch_Valid), 32'h0);
      check_val("rd_pc_out", Pc_Out, 32'h0);
      check_val("rd_addr", Imem_Addr, 32'h0);
      tick();

      // randomized traffic against the model
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         r               = int'($urandom_range(0, 19));
         Reset           = ($urandom_range(0, 199) != 0);
         Is_JAL          = (r == 0);
         Is_JAL_R        = (r == 1);
         Is_Branch_Taken = (r == 2);
         Branch_Address  = $urandom;
         Imem_Ack        = ($urandom_range(0, 1) != 0);
         Imem_Rdata      = $urandom;
         Decode_Ready    = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
